// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall sequencer: stall bus type,
// Stop/NoStop levels, canonical stall patterns and hold-FSM encodings.
package pipe_stall_ctrl_pkg;

  localparam int STALL_BUS_W = 6;

  typedef logic [STALL_BUS_W-1:0] stall_bus_t;

  // Per-stage stall level on the bus
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Stall bus bit positions
  localparam int STALL_BIT_PC = 0;
  localparam int STALL_BIT_IF = 1;

  // Canonical stall patterns: ID hazard freezes PC/IF/ID, EX busy adds EX
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;

  typedef enum logic {
    HOLD_RUN  = 1'b0,
    HOLD_HOLD = 1'b1
  } hold_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_inst_hold_buf.sv
// Instruction hold buffer: freezes the synchronous SRAM read word while the
// front end is stalled and switches back to the live word when released.
module inst_hold_buf
  import pipe_stall_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] inst_out,
  output logic        inst_held
);

  hold_state_e state_q;
  hold_state_e state_d;
  logic [31:0] inst_buf;

  // State register
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the word valid in the first stall cycle; later stall cycles keep it
  // NOTE: the buffer is cleared on reset so a held word is never undefined,
  // even though it is only observed after a fresh capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_buf <= 32'h0;
    end else if (state_q == HOLD_RUN && stall_if == STOP) begin
      inst_buf <= inst_sram_rdata;
    end
  end

  // Next-state logic and output mux
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    inst_out  = inst_sram_rdata;
    inst_held = 1'b0;
    case (state_q)
      HOLD_RUN: begin
        if (stall_if == STOP) state_d = HOLD_HOLD;
      end
      HOLD_HOLD: begin
        inst_out  = inst_buf;
        inst_held = 1'b1;
        if (stall_if == NO_STOP) state_d = HOLD_RUN;
      end
      default: state_d = HOLD_RUN;
    endcase
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall sequencer for the 5-stage pipeline: merges ID/EX stall
// requests onto the stall bus, owns the instruction hold buffer and raises a
// sticky watchdog on runaway stalls.
// Optional macro STALL_PERF_CNT_EN adds the stall_cycles performance counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int STALL_W   = STALL_BUS_W,
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_from_id,
  input  logic               stallreq_from_ex,
  input  logic [31:0]        inst_sram_rdata,
  output logic [STALL_W-1:0] stall,
  output logic [31:0]        inst_out,
  output logic               inst_held,
  output logic               stall_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  stall_bus_t       stall_enc;
  logic [CNT_W-1:0] scnt;

  // Stall encode: EX busy outranks the ID load-use hazard; MEM/WB never stop
  always_comb begin
    stall_enc = STALL_NONE;
    if (stallreq_from_ex) begin
      stall_enc = STALL_EX;
    end else if (stallreq_from_id) begin
      stall_enc = STALL_ID;
    end
  end

  assign stall = STALL_W'(stall_enc);

  inst_hold_buf u_inst_hold_buf (
    .clk             (clk),
    .rst             (rst),
    .stall_if        (stall_enc[STALL_BIT_IF]),
    .inst_sram_rdata (inst_sram_rdata),
    .inst_out        (inst_out),
    .inst_held       (inst_held)
  );

  // Consecutive-stall counter, saturating at MAX_STALL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
    end else if (stall_enc[STALL_BIT_PC] == STOP) begin
      if (scnt != CNT_W'(MAX_STALL)) scnt <= scnt + 1'b1;
    end else begin
      scnt <= '0;
    end
  end

  // Watchdog: sets on the edge the counter reaches MAX_STALL, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_timeout <= 1'b0;
    end else if (stall_enc[STALL_BIT_PC] == STOP && scnt == CNT_W'(MAX_STALL - 1)) begin
      stall_timeout <= 1'b1;
    end
  end

`ifdef STALL_PERF_CNT_EN
  // Total stalled cycles, wrapping modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'h0;
    end else if (stall_enc[STALL_BIT_PC] == STOP) begin
      stall_cycles <= stall_cycles + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random
// request traffic, compared against a behavioural model of the stall rules.
module tb_pipe_stall_ctrl;

  localparam int MAX_STALL = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_from_id = 1'b0;
  logic        stallreq_from_ex = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic [5:0]  stall;
  logic [31:0] inst_out;
  logic        inst_held;
  logic        stall_timeout;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic        m_held;     // previous cycle had IF stalled
  logic [31:0] m_buf;      // word seen in the first cycle of the current IF stall run
  int          m_run;      // length of the current run of PC-stalled cycles
  logic        m_timeout;
  logic [31:0] m_cycles;

  pipe_stall_ctrl #(.MAX_STALL(MAX_STALL)) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .inst_sram_rdata  (inst_sram_rdata),
    .stall            (stall),
    .inst_out         (inst_out),
    .inst_held        (inst_held),
    .stall_timeout    (stall_timeout)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cycles     (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stall pattern as "number of stopped stages from the PC upward"
  function automatic logic [5:0] model_stall(input logic id, input logic ex);
    int n;
    n = ex ? 4 : (id ? 3 : 0);
    return 6'((1 << n) - 1);
  endfunction

  function automatic void model_reset();
    m_held    = 1'b0;
    m_buf     = 32'h0;
    m_run     = 0;
    m_timeout = 1'b0;
    m_cycles  = 32'h0;
  endfunction

  // Advance the model across one rising edge with the given stall pattern
  function automatic void model_edge(input logic [5:0] s, input logic [31:0] rd);
    if (s[1]) begin
      if (!m_held) m_buf = rd;
      m_held = 1'b1;
    end else begin
      m_held = 1'b0;
    end
    m_run = s[0] ? m_run + 1 : 0;
    if (m_run >= MAX_STALL) m_timeout = 1'b1;
    if (s[0]) m_cycles = m_cycles + 32'h1;
  endfunction

  task automatic check_outputs(input logic [5:0] es, input logic [31:0] rd);
    check("stall", 32'(stall), 32'(es));
    check("inst_held", 32'(inst_held), 32'(m_held));
    check("inst_out", inst_out, m_held ? m_buf : rd);
    check("stall_timeout", 32'(stall_timeout), 32'(m_timeout));
`ifdef STALL_PERF_CNT_EN
    check("stall_cycles", stall_cycles, m_cycles);
`endif
  endtask

  // One pipeline cycle: drive at negedge, check mid-cycle, update model at posedge
  task automatic step(input logic id, input logic ex, input logic [31:0] rd);
    logic [5:0] es;
    @(negedge clk);
    stallreq_from_id = id;
    stallreq_from_ex = ex;
    inst_sram_rdata  = rd;
    #1;
    es = model_stall(id, ex);
    check_outputs(es, rd);
    @(posedge clk);
    model_edge(es, rd);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_timeout", 32'(stall_timeout), 32'h0);
    check("rst_held", 32'(inst_held), 32'h0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset state, stall follows requests during reset
    #2;
    check("reset_held", 32'(inst_held), 32'h0);
    check("reset_timeout", 32'(stall_timeout), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    stallreq_from_ex = 1'b1;
    #1;
    check("reset_stall_follows", 32'(stall), 32'h0000000f);
    stallreq_from_ex = 1'b0;
    inst_sram_rdata  = 32'h12345678;
    #1;
    check("reset_inst_out", inst_out, 32'h12345678);
    @(negedge clk);
    rst = 1'b0;

    // ID stall for one cycle
    step(1'b1, 1'b0, 32'h8C220004);
    step(1'b0, 1'b0, 32'hDEADBEEF);
    check("id_hold_word", inst_out, 32'h8C220004);
    step(1'b0, 1'b0, 32'h00000001);
    check("id_released", 32'(inst_held), 32'h0);

    // Both requests, then drop EX while IF stays stalled
    step(1'b1, 1'b1, 32'hAAAA0001);
    step(1'b1, 1'b0, 32'hAAAA0002);
    check("ex_to_id_buf", inst_out, 32'hAAAA0001);
    step(1'b0, 1'b1, 32'hAAAA0003);
    step(1'b0, 1'b0, 32'hAAAA0004);

    // Back-to-back stalls with a single free cycle recapture the buffer
    step(1'b1, 1'b0, 32'hB0000001);
    step(1'b0, 1'b0, 32'hB0000002);
    step(1'b1, 1'b0, 32'hB0000003);
    step(1'b0, 1'b0, 32'hB0000004);
    check("recapture", inst_out, 32'hB0000003);

    // Watchdog: 64 consecutive EX stalls set the flag, it survives release
    for (int i = 0; i < MAX_STALL; i++) step(1'b0, 1'b1, $urandom);
    step(1'b0, 1'b0, $urandom);
    check("timeout_set", 32'(stall_timeout), 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, $urandom);
    check("timeout_sticky", 32'(stall_timeout), 32'h1);
    pulse_reset();

    // 63 stalls, one free cycle, 63 more: no timeout
    for (int i = 0; i < MAX_STALL - 1; i++) step(1'b0, 1'b1, $urandom);
    step(1'b0, 1'b0, $urandom);
    for (int i = 0; i < MAX_STALL - 1; i++) step(1'b0, 1'b1, $urandom);
    step(1'b0, 1'b0, $urandom);
    check("no_timeout_63", 32'(stall_timeout), 32'h0);
    // One more full run proves the count restarted from zero after the gap
    for (int i = 0; i < MAX_STALL - 1; i++) step(1'b1, 1'b0, $urandom);
    step(1'b1, 1'b0, $urandom);
    step(1'b0, 1'b0, $urandom);
    check("timeout_after_64", 32'(stall_timeout), 32'h1);
    pulse_reset();

    // Asynchronous reset mid-HOLD, between clock edges
    step(1'b1, 1'b0, 32'hC0DE0001);
    step(1'b1, 1'b0, 32'hC0DE0002);
    @(negedge clk);
    inst_sram_rdata = 32'hC0DE0003;
    #1;
    check("pre_rst_held", 32'(inst_held), 32'h1);
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_held", 32'(inst_held), 32'h0);
    check("async_rst_inst_out", inst_out, 32'hC0DE0003);
    check("async_rst_stall", 32'(stall), 32'h00000007);
    #1;
    rst = 1'b0;
    @(posedge clk);
    model_edge(model_stall(1'b1, 1'b0), 32'hC0DE0003);
    step(1'b0, 1'b0, 32'hC0DE0004);

`ifdef STALL_PERF_CNT_EN
    // Five ID stalls of three cycles each
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom);
      step(1'b0, 1'b0, $urandom);
    end
    check("perf_15", stall_cycles, 32'd15);
`endif

    // Random request traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
